// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 mouse receiver.
// - frame_state_e : bit-level frame FSM states
// - pkt_state_e   : 3-byte packet assembler states
// - SyncBit       : bit of the first packet byte that is always 1
// - *Off          : field offsets inside the 25-bit ps2_mouse bus
package ps2_pkg;

  typedef enum logic [1:0] {FrmIdle, FrmData, FrmParity, FrmStop} frame_state_e;
  typedef enum logic [1:0] {PktB0, PktB1, PktB2} pkt_state_e;

  localparam int unsigned SyncBit   = 3;
  localparam int unsigned ToggleOff = 24;
  localparam int unsigned DyOff     = 16;
  localparam int unsigned DxOff     = 8;
  localparam int unsigned StatOff   = 0;

endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 frame receiver: synchronises and glitch-filters the raw lines, then
// deserialises one 11-bit frame (start, 8 data LSB first, odd parity, stop).
// Ports:
//   clk_i, rst_ni   : clock, asynchronous active-low reset
//   ps2_clk_i       : raw PS/2 clock
//   ps2_data_i      : raw PS/2 data
//   rx_byte_o       : received data byte (valid with byte_valid_o)
//   byte_valid_o    : 1-cycle pulse, good frame received
//   parity_err_o    : 1-cycle pulse, parity check failed
//   frame_err_o     : 1-cycle pulse, bad start/stop bit or bit timeout
module ps2_frame_rx
  import ps2_pkg::*;
#(
  parameter int unsigned FilterLen  = 8,
  parameter int unsigned BitTimeout = 6000
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       ps2_clk_i,
  input  logic       ps2_data_i,
  output logic [7:0] rx_byte_o,
  output logic       byte_valid_o,
  output logic       parity_err_o,
  output logic       frame_err_o
);

  localparam int unsigned FW = $clog2(FilterLen + 1);
  localparam int unsigned TW = $clog2(BitTimeout + 1);
  localparam logic [FW-1:0] FiltLast = FW'(FilterLen - 1);
  localparam logic [TW-1:0] TimerLast = TW'(BitTimeout - 1);

  logic          clk_s1_q, clk_s2_q, data_s1_q, data_s2_q;
  logic          filt_q, filt_d;
  logic [FW-1:0] fcnt_q, fcnt_d;
  logic          fall;
  frame_state_e  frm_q, frm_d;
  logic [7:0]    shift_q, shift_d;
  logic [2:0]    cnt_q, cnt_d;
  logic          par_q, par_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          timeout;

  // Synchronisers reset to the idle-high bus level so reset never looks like an edge.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      clk_s1_q  <= 1'b1;
      clk_s2_q  <= 1'b1;
      data_s1_q <= 1'b1;
      data_s2_q <= 1'b1;
      filt_q    <= 1'b1;
      fcnt_q    <= '0;
      frm_q     <= FrmIdle;
      shift_q   <= '0;
      cnt_q     <= '0;
      par_q     <= 1'b0;
      timer_q   <= '0;
    end else begin
      clk_s1_q  <= ps2_clk_i;
      clk_s2_q  <= clk_s1_q;
      data_s1_q <= ps2_data_i;
      data_s2_q <= data_s1_q;
      filt_q    <= filt_d;
      fcnt_q    <= fcnt_d;
      frm_q     <= frm_d;
      shift_q   <= shift_d;
      cnt_q     <= cnt_d;
      par_q     <= par_d;
      timer_q   <= timer_d;
    end
  end

  // Filtered level flips on the FilterLen-th consecutive sample that disagrees with it.
  always_comb begin
    filt_d = filt_q;
    fcnt_d = '0;
    fall   = 1'b0;
    if (clk_s2_q != filt_q) begin
      if (fcnt_q == FiltLast) begin
        filt_d = ~filt_q;
        fall   = filt_q;
      end else begin
        fcnt_d = fcnt_q + FW'(1);
      end
    end
  end

  assign timeout = (frm_q != FrmIdle) && (timer_q == TimerLast);

  always_comb begin
    frm_d        = frm_q;
    shift_d      = shift_q;
    cnt_d        = cnt_q;
    par_d        = par_q;
    timer_d      = (frm_q != FrmIdle) ? timer_q + TW'(1) : '0;
    byte_valid_o = 1'b0;
    parity_err_o = 1'b0;
    frame_err_o  = 1'b0;
    if (timeout) begin
      // Timeout beats a coincident edge.
      frame_err_o = 1'b1;
      frm_d       = FrmIdle;
      timer_d     = '0;
    end else if (fall) begin
      timer_d = '0;
      unique case (frm_q)
        FrmIdle: begin
          if (data_s2_q) begin
            frame_err_o = 1'b1;
          end else begin
            frm_d = FrmData;
            cnt_d = '0;
          end
        end
        FrmData: begin
          shift_d = {data_s2_q, shift_q[7:1]};
          cnt_d   = cnt_q + 3'd1;
          if (cnt_q == 3'd7) frm_d = FrmParity;
        end
        FrmParity: begin
          par_d = data_s2_q;
          frm_d = FrmStop;
        end
        FrmStop: begin
          frm_d = FrmIdle;
          if (!data_s2_q)             frame_err_o  = 1'b1;
          else if (^{shift_q, par_q}) byte_valid_o = 1'b1;
          else                        parity_err_o = 1'b1;
        end
        default: frm_d = FrmIdle;
      endcase
    end
  end

  assign rx_byte_o = shift_q;

endmodule

// File: rtl/ps2_mouse_rx.sv
// PS/2 mouse receiver: assembles 3-byte standard mouse packets from checked
// frames and publishes them as {toggle, dy, dx, status}.
// Ports:
//   clk_sys    : system clock
//   reset_n    : asynchronous active-low reset
//   ps2_clk    : raw PS/2 clock
//   ps2_data   : raw PS/2 data
//   ps2_mouse  : [24] toggle per packet, [23:16] dy, [15:8] dx, [7:0] status
//   parity_err : 1-cycle pulse on a parity failure
//   frame_err  : 1-cycle pulse on a start/stop/timeout failure
module ps2_mouse_rx
  import ps2_pkg::*;
#(
  parameter int unsigned FilterLen  = 8,
  parameter int unsigned BitTimeout = 6000,
  parameter int unsigned PktTimeout = 100000
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        ps2_clk,
  input  logic        ps2_data,
  output logic [24:0] ps2_mouse,
  output logic        parity_err,
  output logic        frame_err
);

  localparam int unsigned PW = $clog2(PktTimeout + 1);
  localparam logic [PW-1:0] PktLast = PW'(PktTimeout - 1);

  logic [7:0]    rx_byte;
  logic          byte_valid, perr, ferr;
  pkt_state_e    pkt_q, pkt_d;
  logic [7:0]    stat_q, stat_d, dx_q, dx_d;
  logic [24:0]   mouse_q, mouse_d;
  logic [PW-1:0] ptimer_q, ptimer_d;
  logic          perr_q, ferr_q;

  ps2_frame_rx #(
    .FilterLen (FilterLen),
    .BitTimeout(BitTimeout)
  ) u_frame_rx (
    .clk_i       (clk_sys),
    .rst_ni      (reset_n),
    .ps2_clk_i   (ps2_clk),
    .ps2_data_i  (ps2_data),
    .rx_byte_o   (rx_byte),
    .byte_valid_o(byte_valid),
    .parity_err_o(perr),
    .frame_err_o (ferr)
  );

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      pkt_q    <= PktB0;
      stat_q   <= '0;
      dx_q     <= '0;
      mouse_q  <= '0;
      ptimer_q <= '0;
      perr_q   <= 1'b0;
      ferr_q   <= 1'b0;
    end else begin
      pkt_q    <= pkt_d;
      stat_q   <= stat_d;
      dx_q     <= dx_d;
      mouse_q  <= mouse_d;
      ptimer_q <= ptimer_d;
      perr_q   <= perr;
      ferr_q   <= ferr;
    end
  end

  always_comb begin
    pkt_d    = pkt_q;
    stat_d   = stat_q;
    dx_d     = dx_q;
    mouse_d  = mouse_q;
    ptimer_d = (pkt_q != PktB0) ? ptimer_q + PW'(1) : '0;
    if (perr || ferr) begin
      pkt_d    = PktB0;
      ptimer_d = '0;
    end else if (byte_valid) begin
      ptimer_d = '0;
      unique case (pkt_q)
        PktB0: begin
          // Bytes without the sync bit cannot start a packet.
          if (rx_byte[SyncBit]) begin
            stat_d = rx_byte;
            pkt_d  = PktB1;
          end
        end
        PktB1: begin
          dx_d  = rx_byte;
          pkt_d = PktB2;
        end
        PktB2: begin
          mouse_d[ToggleOff]    = ~mouse_q[ToggleOff];
          mouse_d[DyOff +: 8]   = rx_byte;
          mouse_d[DxOff +: 8]   = dx_q;
          mouse_d[StatOff +: 8] = stat_q;
          pkt_d                 = PktB0;
        end
        default: pkt_d = PktB0;
      endcase
    end else if (pkt_q != PktB0 && ptimer_q == PktLast) begin
      pkt_d    = PktB0;
      ptimer_d = '0;
    end
  end

  assign ps2_mouse  = mouse_q;
  assign parity_err = perr_q;
  assign frame_err  = ferr_q;

endmodule

// File: tb/tb_ps2_mouse_rx.sv
module tb_ps2_mouse_rx;

  localparam int unsigned FilterLen  = 4;
  localparam int unsigned BitTimeout = 200;
  localparam int unsigned PktTimeout = 1500;
  localparam int Half = 20;  // PS/2 half period in clk_sys cycles
  localparam int Gap  = 40;  // idle between bytes

  logic        clk_sys = 1'b0;
  logic        reset_n = 1'b0;
  logic        ps2_clk = 1'b1;
  logic        ps2_data = 1'b1;
  logic [24:0] ps2_mouse;
  logic        parity_err, frame_err;

  ps2_mouse_rx #(
    .FilterLen (FilterLen),
    .BitTimeout(BitTimeout),
    .PktTimeout(PktTimeout)
  ) dut (
    .clk_sys   (clk_sys),
    .reset_n   (reset_n),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .ps2_mouse (ps2_mouse),
    .parity_err(parity_err),
    .frame_err (frame_err)
  );

  always #5 clk_sys = ~clk_sys;

  int checks = 0;
  int errors = 0;

  // Event counters observed on the outputs.
  int tog_cnt = 0, perr_cnt = 0, ferr_cnt = 0, stray_cnt = 0;
  logic        prev_tog  = 1'b0;
  logic [23:0] prev_data = '0;

  always @(negedge clk_sys) begin
    if (reset_n) begin
      if (parity_err) perr_cnt <= perr_cnt + 1;
      if (frame_err)  ferr_cnt <= ferr_cnt + 1;
      if (ps2_mouse[24] != prev_tog) tog_cnt <= tog_cnt + 1;
      else if (ps2_mouse[23:0] != prev_data) stray_cnt <= stray_cnt + 1;
    end
    prev_tog  <= ps2_mouse[24];
    prev_data <= ps2_mouse[23:0];
  end

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk_sys);
    #1;
  endtask

  // Bits are sent LSB first; data changes while the clock is high.
  task automatic send_bits(input logic [10:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      ps2_data = bits[i];
      wait_cyc(Half);
      ps2_clk = 1'b0;
      wait_cyc(Half);
      ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit flip_par, input bit bad_stop);
    logic par;
    par = (~^b) ^ flip_par;
    send_bits({~bad_stop, par, b, 1'b0}, 11);
    wait_cyc(Gap);
  endtask

  // Reference model of the packet rules.
  int          m_idx = 0;
  logic [7:0]  m_pk [3];
  logic [23:0] m_mouse = '0;
  int          m_tog = 0;

  function automatic void model_feed(input logic [7:0] b);
    if (m_idx == 0 && !b[3]) return;
    m_pk[m_idx] = b;
    m_idx++;
    if (m_idx == 3) begin
      m_mouse = {m_pk[2], m_pk[1], m_pk[0]};
      m_tog++;
      m_idx = 0;
    end
  endfunction

  typedef struct packed {
    logic [2:0]  n;
    logic [47:0] bytes;  // first byte in the low octet
    logic [23:0] exp;
    logic [1:0]  tog;
  } vec_t;

  vec_t vecs [4];

  int t0, p0, f0, exp_bit;

  task automatic snap();
    t0 = tog_cnt; p0 = perr_cnt; f0 = ferr_cnt;
  endtask

  task automatic check_deltas(input string tag, input int dt, input int dp, input int df);
    check({tag, " toggles"}, tog_cnt - t0, dt);
    check({tag, " parity_err"}, perr_cnt - p0, dp);
    check({tag, " frame_err"}, ferr_cnt - f0, df);
  endtask

  initial begin
    vecs[0] = '{3'd3, 48'h0000_00FB_0509, 24'hFB0509, 2'd1};
    vecs[1] = '{3'd4, 48'h0000_2010_0802, 24'h201008, 2'd1};
    vecs[2] = '{3'd4, 48'h0000_807F_18F7, 24'h807F18, 2'd1};
    vecs[3] = '{3'd6, 48'h0000_0C55_AA08, 24'h00000C, 2'd2};

    wait_cyc(3);
    check("reset ps2_mouse", int'(ps2_mouse), 0);
    check("reset parity_err", int'(parity_err), 0);
    check("reset frame_err", int'(frame_err), 0);
    reset_n = 1'b1;
    wait_cyc(10);

    // Table-driven packets.
    exp_bit = 0;
    for (int v = 0; v < 4; v++) begin
      snap();
      for (int j = 0; j < int'(vecs[v].n); j++) send_byte(vecs[v].bytes[8*j +: 8], 0, 0);
      wait_cyc(20);
      exp_bit = exp_bit ^ int'(vecs[v].tog[0]);
      check($sformatf("vec%0d data", v), int'(ps2_mouse[23:0]), int'(vecs[v].exp));
      check($sformatf("vec%0d toggle bit", v), int'(ps2_mouse[24]), exp_bit);
      check_deltas($sformatf("vec%0d", v), int'(vecs[v].tog), 0, 0);
    end

    // Parity error in B0: the bad 0x08 must not open a packet.
    snap();
    send_byte(8'h08, 1, 0);
    send_byte(8'h10, 0, 0);
    send_byte(8'h20, 0, 0);
    wait_cyc(20);
    check_deltas("parity B0", 0, 1, 0);
    check("parity B0 data held", int'(ps2_mouse[23:0]), 24'h00000C);

    // Parity error in B1 discards the partial packet.
    snap();
    send_byte(8'h08, 0, 0);
    send_byte(8'h77, 1, 0);
    send_byte(8'h11, 0, 0);
    send_byte(8'h22, 0, 0);
    send_byte(8'h08, 0, 0);
    send_byte(8'h33, 0, 0);
    send_byte(8'h44, 0, 0);
    wait_cyc(20);
    check_deltas("parity B1", 1, 1, 0);
    check("parity B1 data", int'(ps2_mouse[23:0]), 24'h443308);

    // Bad stop bit with bad parity too: only a frame error.
    snap();
    send_byte(8'h08, 1, 1);
    wait_cyc(20);
    check_deltas("bad stop", 0, 0, 1);

    // Bad start bit: one clock pulse with data high.
    snap();
    send_bits(11'h7FF, 1);
    wait_cyc(40);
    check_deltas("bad start", 0, 0, 1);

    // Bit timeout mid byte 3, then a clean packet.
    snap();
    send_byte(8'h08, 0, 0);
    send_byte(8'h01, 0, 0);
    send_bits(11'b000_0101_0100, 5);
    wait_cyc(BitTimeout + 60);
    check_deltas("bit timeout", 0, 0, 1);
    snap();
    send_byte(8'h18, 0, 0);
    send_byte(8'h7F, 0, 0);
    send_byte(8'h80, 0, 0);
    wait_cyc(20);
    check_deltas("after timeout", 1, 0, 0);
    check("after timeout data", int'(ps2_mouse[23:0]), 24'h807F18);

    // Packet timeout resyncs to byte 0 silently.
    snap();
    send_byte(8'h08, 0, 0);
    send_byte(8'h01, 0, 0);
    wait_cyc(PktTimeout + 200);
    send_byte(8'h28, 0, 0);
    send_byte(8'h02, 0, 0);
    send_byte(8'h03, 0, 0);
    wait_cyc(20);
    check_deltas("pkt timeout", 1, 0, 0);
    check("pkt timeout data", int'(ps2_mouse[23:0]), 24'h030228);

    // Short low glitches on ps2_clk while idle.
    snap();
    for (int g = 1; g < int'(FilterLen); g++) begin
      ps2_clk = 1'b0;
      wait_cyc(g);
      ps2_clk = 1'b1;
      wait_cyc(20);
    end
    check_deltas("glitch", 0, 0, 0);

    // Reset mid-frame: outputs clear immediately.
    send_bits(11'b000_0000_0110, 3);
    #3;
    reset_n = 1'b0;
    #1;
    check("mid reset ps2_mouse", int'(ps2_mouse), 0);
    check("mid reset errs", int'({parity_err, frame_err}), 0);
    wait_cyc(5);
    reset_n = 1'b1;
    wait_cyc(10);
    snap();
    send_byte(8'h09, 0, 0);
    send_byte(8'h05, 0, 0);
    send_byte(8'hFB, 0, 0);
    wait_cyc(20);
    check_deltas("post reset", 1, 0, 0);
    check("post reset data", int'(ps2_mouse[23:0]), 24'hFB0509);
    check("post reset toggle bit", int'(ps2_mouse[24]), 1);

    // Randomised bytes against the reference model.
    m_idx = 0;
    m_mouse = 24'hFB0509;
    m_tog = 0;
    snap();
    begin
      int m_perr = 0;
      for (int r = 0; r < 12; r++) begin
        int nb;
        nb = $urandom_range(1, 4);
        for (int j = 0; j < nb; j++) begin
          logic [7:0] b;
          bit err;
          b   = 8'($urandom);
          err = ($urandom_range(0, 5) == 0);
          send_byte(b, err, 0);
          if (err) begin
            m_perr++;
            m_idx = 0;
          end else begin
            model_feed(b);
          end
        end
        wait_cyc(20);
        check($sformatf("rand%0d data", r), int'(ps2_mouse[23:0]), int'(m_mouse));
        check($sformatf("rand%0d toggles", r), tog_cnt - t0, m_tog);
        check($sformatf("rand%0d toggle bit", r), int'(ps2_mouse[24]), (1 + m_tog) % 2);
        check($sformatf("rand%0d parity_err", r), perr_cnt - p0, m_perr);
      end
    end
    check("random frame_err", ferr_cnt - f0, 0);
    check("data changed without toggle", stray_cnt, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
